// File: rtl/wave_sound_mc.sv
// ---------------------------------------------------------------------------
// wave_sound_mc : multi-channel wave-sample player
//
// Holds start/end/pointer/loop/active state per voice. On every sample tick
// it sweeps the voices in round-robin order: one ROM read address per voice
// is issued on O_DMA_ADDR, the ROM returns the byte one clock later, and each
// active voice's sample is converted from offset binary to signed and summed
// into a single mix word.
//
// Ports
//   I_CLK       system clock
//   I_RSTn      asynchronous active-low reset
//   I_TICK      one-cycle sample-rate strobe (ignored while a sweep runs)
//   I_DMA_TRIG  start voice I_DMA_CHAN at I_DMA_ADDR for I_DMA_LEN bytes
//   I_DMA_STOP  stop voice I_DMA_CHAN (wins over a simultaneous trigger)
//   I_DMA_CHAN  target voice for trigger/stop
//   I_DMA_ADDR  sample start address
//   I_DMA_LEN   sample length in bytes (0 = trigger ignored)
//   I_DMA_LOOP  1 = restart at the start address after the last byte
//   O_DMA_ADDR  registered wave ROM read address
//   I_DMA_DATA  wave ROM data, one clock after the address is sampled
//   O_SND       signed mix of all active voices
//   O_SND_VLD   one-cycle pulse when O_SND updates
//   O_ACTIVE    per-voice playing flags
// ---------------------------------------------------------------------------
module wave_sound_mc #(
   parameter int CHANNELS = 8,
   parameter int ADDR_W   = 17,
   parameter int DATA_W   = 8,
   parameter int CH_W     = $clog2(CHANNELS),
   parameter int OUT_W    = DATA_W + CH_W
) (
   input  logic                     I_CLK,
   input  logic                     I_RSTn,
   input  logic                     I_TICK,
   input  logic                     I_DMA_TRIG,
   input  logic                     I_DMA_STOP,
   input  logic [CH_W-1:0]          I_DMA_CHAN,
   input  logic [ADDR_W-1:0]        I_DMA_ADDR,
   input  logic [ADDR_W-1:0]        I_DMA_LEN,
   input  logic                     I_DMA_LOOP,
   output logic [ADDR_W-1:0]        O_DMA_ADDR,
   input  logic [DATA_W-1:0]        I_DMA_DATA,
   output logic signed [OUT_W-1:0]  O_SND,
   output logic                     O_SND_VLD,
   output logic [CHANNELS-1:0]      O_ACTIVE
);

   // r_cyc numbers the clock edges of a sweep: edge 1..CHANNELS-1 issue
   // addresses for voices 1.., edge 2..CHANNELS+1 capture voice (edge-2),
   // edge CHANNELS+2 publishes the mix.
   localparam int CYC_W = $clog2(CHANNELS + 3);
   localparam logic [CYC_W-1:0] CYC_ONE        = CYC_W'(1);
   localparam logic [CYC_W-1:0] CYC_CAP_FIRST  = CYC_W'(2);
   localparam logic [CYC_W-1:0] CYC_LAST_ISSUE = CYC_W'(CHANNELS - 1);
   localparam logic [CYC_W-1:0] CYC_CAP_LAST   = CYC_W'(CHANNELS + 1);
   localparam logic [CYC_W-1:0] CYC_OUT        = CYC_W'(CHANNELS + 2);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FLUSH} state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [CYC_W-1:0]         r_cyc;
   logic signed [OUT_W-1:0]  r_acc;

   logic [ADDR_W-1:0]        r_ptr   [CHANNELS];
   logic [ADDR_W-1:0]        r_start [CHANNELS];
   logic [ADDR_W-1:0]        r_end   [CHANNELS];
   logic [CHANNELS-1:0]      r_loop;
   logic [CHANNELS-1:0]      r_active;

   logic                     w_issue;
   logic [CH_W-1:0]          w_issue_ch;
   logic                     w_cap;
   logic [CH_W-1:0]          w_cap_ch;
   logic                     w_out;
   logic signed [OUT_W-1:0]  w_contrib;
   logic                     w_trig_ok;
   logic [ADDR_W-1:0]        w_end_addr;

   // Offset binary to two's complement: flipping the MSB subtracts the
   // midpoint; the result is then sign-extended to the mix width.
   function automatic logic signed [OUT_W-1:0] f_to_signed(input logic [DATA_W-1:0] d);
      logic [DATA_W-1:0] s;
      s = {~d[DATA_W-1], d[DATA_W-2:0]};
      return {{(OUT_W-DATA_W){s[DATA_W-1]}}, s};
   endfunction

   // ---- sequencer state register ----
   always_ff @(posedge I_CLK or negedge I_RSTn) begin
      if (!I_RSTn) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_issue_ch  = r_cyc[CH_W-1:0];
      w_cap       = 1'b0;
      w_cap_ch    = CH_W'(r_cyc - CYC_CAP_FIRST);
      w_out       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (I_TICK) w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            w_issue = 1'b1;
            w_cap   = (r_cyc >= CYC_CAP_FIRST);
            if (r_cyc == CYC_LAST_ISSUE) w_state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            w_cap = (r_cyc <= CYC_CAP_LAST);
            w_out = (r_cyc == CYC_OUT);
            if (r_cyc == CYC_OUT) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Inactive voices still get an address slot; their data is discarded here.
   assign w_contrib  = r_active[w_cap_ch] ? f_to_signed(I_DMA_DATA) : '0;
   assign w_trig_ok  = I_DMA_TRIG && !I_DMA_STOP && (I_DMA_LEN != '0);
   assign w_end_addr = I_DMA_ADDR + I_DMA_LEN - ADDR_W'(1);

   // ---- sweep datapath: address issue, accumulate, publish ----
   always_ff @(posedge I_CLK or negedge I_RSTn) begin
      if (!I_RSTn) begin
         r_cyc      <= '0;
         r_acc      <= '0;
         O_DMA_ADDR <= '0;
         O_SND      <= '0;
         O_SND_VLD  <= 1'b0;
      end else begin
         O_SND_VLD <= 1'b0;
         if (r_state == S_IDLE) begin
            if (I_TICK) begin
               r_cyc      <= CYC_ONE;
               r_acc      <= '0;
               O_DMA_ADDR <= r_ptr[0];
            end
         end else begin
            r_cyc <= r_cyc + CYC_ONE;
            if (w_issue) O_DMA_ADDR <= r_ptr[w_issue_ch];
            if (w_cap)   r_acc      <= r_acc + w_contrib;
            if (w_out) begin
               O_SND     <= r_acc;
               O_SND_VLD <= 1'b1;
            end
         end
      end
   end

   // ---- per-voice state: trigger/stop take priority over pointer advance ----
   always_ff @(posedge I_CLK or negedge I_RSTn) begin
      if (!I_RSTn) begin
         for (int c = 0; c < CHANNELS; c++) begin
            r_ptr[c]   <= '0;
            r_start[c] <= '0;
            r_end[c]   <= '0;
         end
         r_loop   <= '0;
         r_active <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (I_DMA_STOP && (I_DMA_CHAN == CH_W'(c))) begin
               r_active[c] <= 1'b0;
            end else if (w_trig_ok && (I_DMA_CHAN == CH_W'(c))) begin
               r_start[c]  <= I_DMA_ADDR;
               r_ptr[c]    <= I_DMA_ADDR;
               r_end[c]    <= w_end_addr;
               r_loop[c]   <= I_DMA_LOOP;
               r_active[c] <= 1'b1;
            end else if (w_cap && (w_cap_ch == CH_W'(c)) && r_active[c]) begin
               // The end byte has just been played; only now wrap or stop.
               if (r_ptr[c] == r_end[c]) begin
                  if (r_loop[c]) r_ptr[c]    <= r_start[c];
                  else           r_active[c] <= 1'b0;
               end else begin
                  r_ptr[c] <= r_ptr[c] + ADDR_W'(1);
               end
            end
         end
      end
   end

   assign O_ACTIVE = r_active;

endmodule
